// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised Moore pattern detector.
// Holds the KMP helpers that the detector evaluates at elaboration time
// to build its next-state logic. No runtime lookup tables are involved.
package seq_det_pkg;

    localparam int MAX_LEN = 16;

    typedef logic [MAX_LEN-1:0] pat_t;

    // Returns ceil(log2(n)). The result is 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Returns the i-th pattern bit in arrival order. i = 0 is the MSB.
    function automatic bit prefix_bit(input pat_t p, input int len, input int i);
        pat_t t;
        t = p >> (len - 1 - i);
        return t[0];
    endfunction

    // Returns the length of the longest proper border of the length-k prefix.
    // A border is a prefix that is also a suffix.
    function automatic int border_len(input pat_t p, input int len, input int k);
        int  best;
        bit  ok;
        best = 0;
        for (int j = 1; j < k; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (prefix_bit(p, len, i) != prefix_bit(p, len, k - j + i))
                    ok = 1'b0;
            end
            if (ok)
                best = j;
        end
        return best;
    endfunction

    // Returns the longest prefix that is a suffix of (length-k prefix, b).
    // The result is capped at len.
    function automatic int next_state(input pat_t p, input int len, input int k, input bit b);
        int best;
        int lim;
        int m;
        bit ok;
        bit sb;
        best = 0;
        if (k >= len)
            return 0;
        lim = (k + 1 < len) ? k + 1 : len;
        for (int j = 1; j <= lim; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                m  = k + 1 - j + i;
                sb = (m < k) ? prefix_bit(p, len, m) : b;
                if (sb != prefix_bit(p, len, i))
                    ok = 1'b0;
            end
            if (ok)
                best = j;
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_moore_param_if.sv
// Serial-stream control and status bundle for the pattern detector.
interface seq_detect_moore_param_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             in;
    logic             overlap;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en, in, overlap, cnt_clr,
        input  out, match_cnt
    );

    modport slave (
        input  en, in, overlap, cnt_clr,
        output out, match_cnt
    );
endinterface

// File: rtl/seq_det_sat_counter.sv
// Saturating event counter with a synchronous clear.
// When clear and increment occur together, the clear takes priority.
module seq_det_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count up until all ones and hold there. A clear forces the count to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (inc && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial pattern detector.
// State k is the length of the longest pattern prefix that matches the most
// recent consumed bits. State LEN is MATCH. From MATCH, the detector
// restarts from S0 in non-overlap mode, or from the pattern's border in
// overlap mode.
module seq_detect_moore_param
    import seq_det_pkg::*;
#(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b101,
    parameter int             CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    seq_detect_moore_param_if.slave  bus
);

    localparam int             SW       = clog2(LEN + 1);
    localparam int             NS       = 1 << SW;
    localparam logic [SW-1:0]  S_MATCH  = SW'(LEN);
    localparam logic [SW-1:0]  S_BORDER = SW'(border_len(pat_t'(PATTERN), LEN, LEN));

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_next;
    logic [SW-1:0] w_base;
    logic          w_inc;
    logic [SW-1:0] w_nxt0 [NS];
    logic [SW-1:0] w_nxt1 [NS];

    // Constant transition targets for every encoding.
    // MATCH and illegal encodings map to S0; MATCH itself is handled separately below.
    for (genvar k = 0; k < NS; k++) begin : g_nxt
        localparam int N0 = (k < LEN) ? next_state(pat_t'(PATTERN), LEN, k, 1'b0) : 0;
        localparam int N1 = (k < LEN) ? next_state(pat_t'(PATTERN), LEN, k, 1'b1) : 0;
        assign w_nxt0[k] = SW'(N0);
        assign w_nxt1[k] = SW'(N1);
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= '0;
        else
            r_state <= w_next;
    end

    // Next state: hold while disabled, otherwise follow the KMP transition.
    always_comb begin
        w_next = r_state;
        w_base = '0;
        if (bus.en) begin
            if (r_state == S_MATCH) begin
                w_base = bus.overlap ? S_BORDER : '0;
                w_next = bus.in ? w_nxt1[w_base] : w_nxt0[w_base];
            end else begin
                w_next = bus.in ? w_nxt1[r_state] : w_nxt0[r_state];
            end
        end
    end

    // Moore output decoded from the registered state only.
    always_comb begin
        bus.out = (r_state == S_MATCH);
    end

    assign w_inc = bus.en && (w_next == S_MATCH);

    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_inc),
        .clr (bus.cnt_clr),
        .cnt (bus.match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Testbench for seq_detect_moore_param.
// Three detector instances share one input stream:
//   a: LEN=3, PATTERN=101,  CNT_W=8
//   b: LEN=4, PATTERN=1101, CNT_W=2
//   c: LEN=3, PATTERN=101,  CNT_W=2
// Each instance is compared against a history-string reference model.
module tb_seq_detect_moore_param;

    logic clk = 1'b0;
    logic rst;
    logic t_en, t_in, t_ovl, t_clr;

    always #5 clk = ~clk;

    seq_detect_moore_param_if #(.CNT_W(8)) if_a ();
    seq_detect_moore_param_if #(.CNT_W(2)) if_b ();
    seq_detect_moore_param_if #(.CNT_W(2)) if_c ();

    assign if_a.en = t_en;  assign if_a.in = t_in;  assign if_a.overlap = t_ovl;  assign if_a.cnt_clr = t_clr;
    assign if_b.en = t_en;  assign if_b.in = t_in;  assign if_b.overlap = t_ovl;  assign if_b.cnt_clr = t_clr;
    assign if_c.en = t_en;  assign if_c.in = t_in;  assign if_c.overlap = t_ovl;  assign if_c.cnt_clr = t_clr;

    seq_detect_moore_param #(.LEN(3), .PATTERN(3'b101), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    seq_detect_moore_param #(.LEN(4), .PATTERN(4'b1101), .CNT_W(2)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    seq_detect_moore_param #(.LEN(3), .PATTERN(3'b101), .CNT_W(2)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    int errors = 0;
    int checks = 0;

    // Reference model: consumed-bit history per instance.
    int m_len [3] = '{3, 4, 3};
    int m_pat [3] = '{5, 13, 5};
    int m_max [3] = '{255, 3, 3};
    int m_hist[3];
    int m_n   [3];
    int m_cnt [3];
    bit m_match[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a_out"}, 32'(if_a.out),       32'(m_match[0]));
        chk({tag, "_a_cnt"}, 32'(if_a.match_cnt), 32'(m_cnt[0]));
        chk({tag, "_b_out"}, 32'(if_b.out),       32'(m_match[1]));
        chk({tag, "_b_cnt"}, 32'(if_b.match_cnt), 32'(m_cnt[1]));
        chk({tag, "_c_out"}, 32'(if_c.out),       32'(m_match[2]));
        chk({tag, "_c_cnt"}, 32'(if_c.match_cnt), 32'(m_cnt[2]));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_hist[d]  = 0;
            m_n[d]     = 0;
            m_cnt[d]   = 0;
            m_match[d] = 1'b0;
        end
    endtask

    // One clock edge of the reference model.
    // In non-overlap mode, a completed match empties the history.
    task automatic model_edge(input bit e, input bit b, input bit o, input bit c);
        int mask;
        for (int d = 0; d < 3; d++) begin
            if (e) begin
                if (m_match[d] && !o) begin
                    m_hist[d] = 0;
                    m_n[d]    = 0;
                end
                m_hist[d] = (m_hist[d] << 1) | int'(b);
                if (m_n[d] < 32) m_n[d]++;
                mask = (1 << m_len[d]) - 1;
                m_match[d] = (m_n[d] >= m_len[d]) && ((m_hist[d] & mask) == m_pat[d]);
            end
            if (c)
                m_cnt[d] = 0;
            else if (e && m_match[d] && (m_cnt[d] < m_max[d]))
                m_cnt[d]++;
        end
    endtask

    task automatic step(input bit e, input bit b, input bit o, input bit c);
        t_en = e; t_in = b; t_ovl = o; t_clr = c;
        @(posedge clk);
        model_edge(e, b, o, c);
        #1;
        check_all("step");
    endtask

    // Assert reset between clock edges, check the outputs immediately, then release it.
    task automatic reset_async();
        t_en = 1'b0; t_clr = 1'b0;
        #3 rst = 1'b0;
        model_reset();
        #1 check_all("rst");
        #2 rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        t_en = 1'b0; t_in = 1'b0; t_ovl = 1'b0; t_clr = 1'b0;
        model_reset();
        #12;
        check_all("por");
        rst = 1'b1;

        // Test 1: non-overlap detection of 101 on the stream 1,0,1,0,1
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        chk("t1_out3", 32'(if_a.out), 1);
        step(1, 0, 0, 0); step(1, 1, 0, 0);
        chk("t1_out5", 32'(if_a.out), 0);
        chk("t1_cnt",  32'(if_a.match_cnt), 1);

        // Test 2: the same stream in overlap mode
        reset_async();
        step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0);
        chk("t2_out3", 32'(if_a.out), 1);
        step(1, 0, 1, 0); step(1, 1, 1, 0);
        chk("t2_out5", 32'(if_a.out), 1);
        chk("t2_cnt",  32'(if_a.match_cnt), 2);

        // Test 3: pattern 1101 with partial-match fallback on 1,1,1,0,1
        reset_async();
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
        chk("t3_out4", 32'(if_b.out), 0);
        step(1, 1, 0, 0);
        chk("t3_out5", 32'(if_b.out), 1);
        chk("t3_cnt",  32'(if_b.match_cnt), 1);

        // Test 4: the detector freezes while en is low
        reset_async();
        step(1, 1, 0, 0);
        step(0, 0, 0, 0); step(0, 1, 1, 0); step(0, 0, 0, 0);
        chk("t4_frozen", 32'(if_a.out), 0);
        step(1, 0, 0, 0); step(1, 1, 0, 0);
        chk("t4_out", 32'(if_a.out), 1);
        chk("t4_cnt", 32'(if_a.match_cnt), 1);

        // Test 5: reset asserted mid-pattern, then a single fresh match
        step(1, 1, 0, 0); step(1, 0, 0, 0);
        reset_async();
        chk("t5_cnt_rst", 32'(if_a.match_cnt), 0);
        step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
        chk("t5_cnt", 32'(if_a.match_cnt), 1);

        // Test 6: counter saturation, then a clear on the same edge as a match
        reset_async();
        for (int i = 0; i < 11; i++)
            step(1, (i % 2 == 0), 1, 0);
        chk("t6_sat", 32'(if_c.match_cnt), 3);
        step(1, 0, 1, 0);
        step(1, 1, 1, 1);
        chk("t6_clr_out", 32'(if_c.out), 1);
        chk("t6_clr_cnt", 32'(if_c.match_cnt), 0);

        // Random stimulus with occasional resets
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 96)
                reset_async();
            else
                step(($urandom % 8) != 0, $urandom % 2 == 1,
                     $urandom % 2 == 1, ($urandom % 16) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_moore_param.md
Name: seq_detect_moore_param

Overview:
Parametrised Moore-style serial bit-pattern detector. It generalises the fixed 3-bit "101" non-overlapping detector to any pattern length and value. Overlap and non-overlap modes are selectable at run time, and the block adds a sample enable and a saturating match counter. It sits on a 1-bit serial input stream and flags pattern occurrences to downstream control logic.

Parameters:
LEN, 3, pattern length in bits; legal range 2..16.
PATTERN, 3'b101, LEN-bit pattern; MSB is received first.
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
en  input  1  sample enable; in is consumed only on edges where en=1
in  input  1  serial data bit
overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled with each consumed bit
cnt_clr  input  1  synchronous clear of match_cnt
out  output  1  Moore output, 1 while FSM is in MATCH state
match_cnt  output  CNT_W  saturating count of MATCH entries since reset or clear

Behaviour:
- States S0..S(LEN-1): Sk means the longest pattern prefix matching the most recent inputs has length k. MATCH corresponds to k=LEN. State register width is clog2(LEN+1).
- Reset (rst=0, asynchronous): state=S0, out=0, match_cnt=0. Reset is honoured at any time, including mid-pattern or while in MATCH. After deassertion the first consumed bit is evaluated from S0.
- en=0: state, out and match_cnt hold. in, overlap and cnt_clr have no effect apart from cnt_clr (see below).
- Transition on a consumed bit b from Sk (k<LEN): next = longest j<=LEN such that PATTERN[LEN-1 -: j] equals the last j bits of (matched prefix, b). This is a KMP failure function, not a reset to S0 on mismatch.
- Transition from MATCH:
  - overlap=0: treat the matched history as empty; next is computed from S0 with bit b.
  - overlap=1: treat the history as the longest proper border of PATTERN; next is computed from that state with bit b. MATCH-to-MATCH is legal, e.g. pattern 11 on input 111.
- out = (state==MATCH). It is registered, with no combinational path from in. out rises in the cycle after the clock edge that consumes the final pattern bit, and lasts exactly one cycle unless the next consumed bit re-enters MATCH, or en=0 holds it.
- match_cnt:
  - Increments by 1 on each edge where next state is MATCH and en=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 sets it to 0 on the next edge regardless of en. If a match occurs on the same edge, clear wins and the result is 0.
- Next-state logic is combinational, derived from the parameters via elaboration-time functions; no runtime tables.
- Illegal state encodings (>MATCH) go to S0 on the next consumed bit.

Decomposition:
- Package seq_det_pkg holds:
  - clog2 helper.
  - Function border_len(pattern, len, k), returning the failure value for prefix length k.
  - Function next_state(pattern, len, k, b).
- RTL instantiates one sub-module, seq_det_sat_counter (CNT_W, inc, clr), for match_cnt. The FSM stays in the top module.

Test Plan:
1. Defaults, overlap=0, en=1, in stream 1,0,1,0,1 after reset release -> out=1 only in the cycle after the 3rd bit; the 5th bit does not re-match; match_cnt=1.
2. Same stream with overlap=1 -> out=1 after the 3rd and after the 5th bit; match_cnt=2.
3. LEN=4, PATTERN=4'b1101, stream 1,1,1,0,1 -> partial-match fallback S2 -> S2 on the 3rd '1'; MATCH after the 5th bit; match_cnt=1.
4. en toggling: apply 1, then en=0 for 3 cycles with in toggling, then 0,1 with en=1 -> state and out frozen during en=0; MATCH after the final bit; match_cnt=1.
5. Reset mid-operation: after bits 1,0, assert rst low asynchronously mid-cycle -> out=0 and match_cnt=0 immediately; next 1,0,1 after release -> single match.
6. CNT_W=2, overlap=1, PATTERN=101, stream 10101010101 -> match_cnt saturates at 3; cnt_clr coincident with a match edge -> match_cnt=0.
